// File: rtl/local_packet_serializer.sv
// Buffers 32-bit spike packets and serializes them MSB-nibble first onto the router local port.
// Optional SERIALIZER_STATS_EN adds saturating sent-packet and drop counters.
module local_packet_serializer #(
    parameter int packet_size    = 32,
    parameter int flit_size      = 4,
    parameter int FIFO_DEPTH_BIT = 2
) (
    input  logic                   rt_clk,
    input  logic                   rt_rst,
    input  logic [packet_size-1:0] packet_in,
    input  logic                   packet_write_req,
    output logic                   packet_buf_full,
    output logic                   packet_buf_empty,
    output logic [flit_size-1:0]   flit_out,
    output logic                   write_req_to_router,
    input  logic                   router_local_full,
    output logic                   packet_drop
`ifdef SERIALIZER_STATS_EN
    ,
    output logic [15:0]            sent_packet_cnt,
    output logic [15:0]            drop_cnt
`endif
);
    localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_BIT;
    localparam int FLITS      = packet_size / flit_size;
    localparam int CNT_W      = (FLITS > 1) ? $clog2(FLITS) : 1;
    localparam logic [FIFO_DEPTH_BIT:0] FULL_COUNT = {1'b1, {FIFO_DEPTH_BIT{1'b0}}};
    localparam logic [CNT_W-1:0]        LAST_CNT   = CNT_W'(FLITS - 1);

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_next;

    logic [packet_size-1:0]    mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_BIT-1:0] rd_ptr, wr_ptr;
    logic [FIFO_DEPTH_BIT:0]   count;
    logic [packet_size-1:0]    shreg;
    logic [CNT_W-1:0]          flit_cnt;
    logic                      fifo_full, fifo_has;
    logic                      pop, push, send, last;

    assign fifo_full        = (count == FULL_COUNT);
    assign fifo_has         = (count != '0);
    assign packet_buf_full  = fifo_full;
    assign packet_buf_empty = !fifo_has && (state == IDLE);

    always_ff @(posedge rt_clk) begin
        if (rt_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        send       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_has) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (!router_local_full) begin
                    send = 1'b1;
                    if (flit_cnt == LAST_CNT) begin
                        last = 1'b1;
                        // chain straight into the next packet so the link sees no bubble
                        if (fifo_has) pop = 1'b1;
                        else          state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // a pop in the same cycle frees the slot, so a write at full is still accepted
        push = packet_write_req && (!fifo_full || pop);
    end

    always_ff @(posedge rt_clk) begin
        if (push) mem[wr_ptr] <= packet_in;
    end

    always_ff @(posedge rt_clk) begin
        if (rt_rst) begin
            rd_ptr              <= '0;
            wr_ptr              <= '0;
            count               <= '0;
            shreg               <= '0;
            flit_cnt            <= '0;
            flit_out            <= '0;
            write_req_to_router <= 1'b0;
            packet_drop         <= 1'b0;
        end else begin
            write_req_to_router <= send;
            packet_drop         <= packet_write_req && !push;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (send) flit_out <= shreg[packet_size-1 -: flit_size];
            if (pop) begin
                shreg    <= mem[rd_ptr];
                flit_cnt <= '0;
            end else if (send) begin
                shreg    <= shreg << flit_size;
                flit_cnt <= flit_cnt + 1'b1;
            end
        end
    end

`ifdef SERIALIZER_STATS_EN
    always_ff @(posedge rt_clk) begin
        if (rt_rst) begin
            sent_packet_cnt <= '0;
            drop_cnt        <= '0;
        end else begin
            if (last && sent_packet_cnt != 16'hFFFF)
                sent_packet_cnt <= sent_packet_cnt + 16'd1;
            if (packet_write_req && !push && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/local_packet_serializer.md
Name: local_packet_serializer

Overview:
- Sits between the neuron core's 32-bit spike packet output and the router's 4-bit local input port, in the router clock domain.
- Buffers whole spike packets in a small FIFO.
- Serializes each packet into 8 flits, most-significant nibble first.
- Drives the router local write request and obeys the router local-port full flag.

Parameters:
- packet_size, 32, width of one spike packet in bits.
- flit_size, 4, width of one flit in bits; packet_size must be an integer multiple of flit_size.
- FIFO_DEPTH_BIT, 2, log2 of packet FIFO depth (default depth 4).

Ports:
- rt_clk  input  1  router clock; the only clock.
- rt_rst  input  1  synchronous, active-high reset.
- packet_in  input  packet_size  spike packet from the neuron core.
- packet_write_req  input  1  one-cycle write strobe for packet_in.
- packet_buf_full  output  1  packet FIFO holds FIFO_DEPTH packets.
- packet_buf_empty  output  1  FIFO holds no packets and no serialization is in progress.
- flit_out  output  flit_size  flit to router local_in.
- write_req_to_router  output  1  flit_out valid this cycle; router writes it.
- router_local_full  input  1  router local input FIFO full.
- packet_drop  output  1  one-cycle pulse when a write arrives while the FIFO is full.

Behaviour:
Reset:
- rt_rst sampled high on a rising rt_clk edge sets every output to 0 except packet_buf_empty=1.
- Also clears the FIFO read/write pointers, the occupancy count, the shift register, the flit counter, and sets state to IDLE.
- Reset mid-packet discards the partial packet; no further flits of it are emitted.

FIFO:
- Depth 1<<FIFO_DEPTH_BIT; occupancy count is FIFO_DEPTH_BIT+1 bits.
- Pointers wrap modulo depth.
- packet_write_req with FIFO not full: packet_in is stored next edge.
- packet_write_req with FIFO full: packet is discarded and packet_drop=1 for the following cycle; FIFO contents are unchanged.
- Simultaneous push and pop when full: the pop frees a slot first, so the push is accepted and no drop occurs.
- Simultaneous push and pop at count 0: not possible, because a pop requires a stored entry.

State machine:
- IDLE:
  - If the FIFO is non-empty: pop the head into the shift register, set flit_cnt=0, go to SEND.
  - Else stay in IDLE; write_req_to_router=0.
- SEND: evaluated every cycle.
  - If router_local_full=0: next edge drives flit_out=shreg[packet_size-1 -: flit_size] and write_req_to_router=1, shifts shreg left by flit_size, and increments flit_cnt.
  - If router_local_full=1: next edge drives write_req_to_router=0, and shreg and flit_cnt hold.
  - flit_out holds its last value when no flit is written.
- Last flit (flit_cnt = packet_size/flit_size-1 while not full):
  - If the FIFO is non-empty, pop the next packet in the same cycle and stay in SEND with flit_cnt=0, so there is no bubble between packets.
  - Else go to IDLE.
- Outputs are registered: router_local_full sampled at edge t gates the flit presented after edge t.
- Latency: packet written at edge 0 → stored edge 0, popped edge 1, first flit valid after edge 2.
- Unstalled, 8 consecutive flits follow on 8 consecutive cycles.
- packet_buf_empty = (count==0) && state==IDLE.
- Flits of one packet are never interleaved with another packet's flits.

Optional Feature:
- Macro: SERIALIZER_STATS_EN.
- Defined:
  - Adds output sent_packet_cnt [15:0]: increments on each last flit written.
  - Adds output drop_cnt [15:0]: increments on each packet_drop.
  - Both counters saturate at 16'hFFFF, reset to 0 on rt_rst, and are registered.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Single packet, no stall: reset 4 cycles, write packet_in=32'h1234ABCD at edge 0, router_local_full=0.
  - write_req_to_router=1 for cycles 2..9 with flit_out 1,2,3,4,A,B,C,D.
  - packet_buf_empty returns to 1 after the last flit.
- Backpressure: same packet; hold router_local_full=1 for the cycle after flit 3 is sent, for 5 cycles.
  - write_req_to_router=0 for exactly those 5 cycles, then flits 4..D follow.
  - No flit is lost or duplicated; 8 requests total.
- Back-to-back: write 32'hFFFF0000 and 32'h0F0F0F0F on consecutive cycles.
  - 16 consecutive write_req_to_router cycles with no bubble; flits F,F,F,F,0,0,0,0,0,F,0,F,0,F,0,F.
- Overflow: router_local_full=1 permanently; write 6 packets on consecutive cycles.
  - Packet 1 is popped into the shift register, packets 2-5 fill the FIFO, and packet_buf_full=1.
  - Packet 6 causes one packet_drop pulse (drop_cnt=1 if SERIALIZER_STATS_EN).
  - After full deasserts, exactly 5 packets (40 flits) are emitted in write order.
- Reset mid-packet: assert rt_rst after flit 3 of a packet with 2 more queued.
  - Next cycle all outputs are 0 and packet_buf_empty=1.
  - No further flits appear until a new packet_write_req.
- Push and pop same cycle at full: FIFO at count 4, serializer finishing its last flit, new write in that same cycle.
  - No packet_drop; the new packet is emitted in order after the 4 already queued.
